interval_timer_arbiter: RTL

//   Shares one programmable interval counter among NREQ requesters.

---
 rtl/interval_timer_arbiter_if.sv | 24 ++
 rtl/interval_timer_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/interval_timer_arbiter_if.sv
// Handshake bundle between the requesting control FSMs (master) and the
// shared interval timer arbiter (slave).
interface interval_timer_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] len;
  logic                  hold;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [NBITS-1:0]      count;

  modport master (
    output req, len, hold,
    input  grant, busy, done, count
  );

  modport slave (
    input  req, len, hold,
    output grant, busy, done, count
  );
endinterface

// File: rtl/interval_timer_arbiter.sv
// One interval counter shared round-robin among NREQ requesters; the winner
// keeps the counter for len+1 cycles and then receives a one-cycle done pulse.
module interval_timer_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  interval_timer_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NBITS-1:0]  count_q, count_d;
  logic [NBITS-1:0]  tc_q, tc_d;
  logic [IW-1:0]     last_q, last_d;

  logic [NBITS-1:0]  len_arr [NREQ];
  logic [IW-1:0]     pick;
  logic              found;
  logic              owner_req;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign len_arr[gi] = bus.len[gi*NBITS +: NBITS];
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // The owner's request level, without needing a separate owner index.
  assign owner_req = |(bus.req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    tc_d    = tc_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        count_d = '0;
        if (found) begin
          grant_d = NREQ'(1) << pick;
          tc_d    = len_arr[pick];
          last_d  = pick;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          grant_d = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (count_q == tc_q) begin
          // Terminal count wins over hold so a paused interval still completes.
          done_d  = grant_q;
          count_d = '0;
          state_d = DONE;
        end else if (!bus.hold) begin
          count_d = count_q + NBITS'(1);
        end
      end
      DONE: begin
        grant_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      tc_q    <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.busy  = |grant_q;

endmodule
